// File: rtl/bf16_fpu_arbiter_pkg.sv
// Shared types and constants for the bf16 FPU arbiter: op codes, exception
// flag bit positions and the arbiter state encoding.
package bf16_fpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD     = 4'd0,
    OP_MAC     = 4'd1,
    OP_MUL     = 4'd2,
    OP_EQ      = 4'd3,
    OP_NE      = 4'd4,
    OP_LE      = 4'd5,
    OP_LT      = 4'd6,
    OP_GE      = 4'd7,
    OP_GT      = 4'd8,
    OP_CLR_ACC = 4'hF
  } op_e;

  // Exception flag bit positions within the 5-bit {NV,DZ,OF,UF,NX} vector
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  // Response flags for an op code the FPU does not implement
  localparam logic [4:0] FLAGS_INVALID = 5'b00001 << FLAG_NV;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/bf16_fpu_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or above
// ptr_i, wrapping around. Produces a one-hot grant, its index and a valid.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     idx_o,
  output logic               vld_o
);

  int pos;

  // Scan requesters starting at the pointer; the first hit wins
  always_comb begin
    gnt_o = {NUM_REQ{1'b0}};
    idx_o = {IDW{1'b0}};
    vld_o = 1'b0;
    pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (int'(ptr_i) + k) % NUM_REQ;
      if (en_i && !vld_o && req_i[pos]) begin
        gnt_o[pos] = 1'b1;
        idx_o      = IDW'(pos);
        vld_o      = 1'b1;
      end else begin
        vld_o = vld_o;
      end
    end
  end

endmodule

// File: rtl/bf16_fpu_arbiter.sv
// Shares one bf16 FPU core between NUM_REQ requesters. One op at a time is
// accepted round-robin, issued to the FPU, waited on for FPU_LATENCY cycles
// and returned on a single response channel with backpressure.
// Optional accumulator lock (MAC sequence exclusivity): BF16_FPU_ARB_LOCK_EN.
module bf16_fpu_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int CTRL_WIDTH  = 4,
  parameter int FPU_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*CTRL_WIDTH-1:0] req_op,
`ifdef BF16_FPU_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_lock,
`endif
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [4:0]                    rsp_flags,
  output logic [DATA_WIDTH-1:0]         fpu_in_a,
  output logic [DATA_WIDTH-1:0]         fpu_in_b,
  output logic [CTRL_WIDTH-1:0]         fpu_op_select,
  output logic                          fpu_write_en,
  output logic                          fpu_clr_acc,
  input  logic [DATA_WIDTH-1:0]         fpu_out_c,
  input  logic [4:0]                    fpu_exc_flags
);

  import bf16_fpu_pkg::*;

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [3:0]            LAT         = 4'(FPU_LATENCY);
  localparam logic [CTRL_WIDTH-1:0] OP_LAST_FPU = CTRL_WIDTH'(OP_GT);
  localparam logic [CTRL_WIDTH-1:0] OP_CLR      = CTRL_WIDTH'(OP_CLR_ACC);

  arb_state_e            state_q, state_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDW-1:0]        id_q, id_d;
  logic                  is_clr_q, is_clr_d;
  logic [DATA_WIDTH-1:0] fpu_a_q, fpu_a_d;
  logic [DATA_WIDTH-1:0] fpu_b_q, fpu_b_d;
  logic [CTRL_WIDTH-1:0] fpu_op_q, fpu_op_d;
  logic                  we_q, we_d;
  logic                  clr_q, clr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]        rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [4:0]            rsp_flags_q, rsp_flags_d;

  logic [NUM_REQ-1:0]    arb_req_s;
  logic [NUM_REQ-1:0]    gnt_s;
  logic [IDW-1:0]        idx_s;
  logic                  accept_s;
  logic                  adv_ptr_s;
  logic [IDW-1:0]        ptr_next_s;
  logic [DATA_WIDTH-1:0] sel_a_s, sel_b_s;
  logic [CTRL_WIDTH-1:0] sel_op_s;
  logic                  sel_fpu_s, sel_clr_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i (arb_req_s),
    .ptr_i (rr_ptr_q),
    .en_i  (state_q == IDLE),
    .gnt_o (gnt_s),
    .idx_o (idx_s),
    .vld_o (accept_s)
  );

  assign req_ready  = gnt_s;
  assign sel_a_s    = req_a[idx_s*DATA_WIDTH +: DATA_WIDTH];
  assign sel_b_s    = req_b[idx_s*DATA_WIDTH +: DATA_WIDTH];
  assign sel_op_s   = req_op[idx_s*CTRL_WIDTH +: CTRL_WIDTH];
  assign sel_clr_s  = (sel_op_s == OP_CLR);
  assign sel_fpu_s  = (sel_op_s <= OP_LAST_FPU) || sel_clr_s;
  assign ptr_next_s = (idx_s == IDW'(NUM_REQ - 1)) ? {IDW{1'b0}} : idx_s + IDW'(1);

`ifdef BF16_FPU_ARB_LOCK_EN
  logic           lock_act_q, lock_act_d;
  logic [IDW-1:0] lock_own_q, lock_own_d;
  logic [4:0]     lock_tmr_q, lock_tmr_d;

  // While locked only the owner may be granted and the pointer stays put
  assign arb_req_s = lock_act_q ? (req_valid & (NUM_REQ'(1) << lock_own_q)) : req_valid;
  assign adv_ptr_s = !lock_act_q;

  // Lock take/release on accept, and idle-owner timeout after 16 cycles
  always_comb begin
    lock_act_d = lock_act_q;
    lock_own_d = lock_own_q;
    lock_tmr_d = 5'd0;
    if (state_q == IDLE && accept_s) begin
      if (req_lock[idx_s]) begin
        lock_act_d = 1'b1;
        lock_own_d = idx_s;
      end else begin
        lock_act_d = 1'b0;
      end
    end else if (state_q == IDLE && lock_act_q && !req_valid[lock_own_q]) begin
      if (lock_tmr_q == 5'd15) begin
        lock_act_d = 1'b0;
      end else begin
        lock_tmr_d = lock_tmr_q + 5'd1;
      end
    end else begin
      lock_tmr_d = 5'd0;
    end
  end

  // Lock state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_act_q <= 1'b0;
      lock_own_q <= {IDW{1'b0}};
      lock_tmr_q <= 5'd0;
    end else begin
      lock_act_q <= lock_act_d;
      lock_own_q <= lock_own_d;
      lock_tmr_q <= lock_tmr_d;
    end
  end
`else
  assign arb_req_s = req_valid;
  assign adv_ptr_s = 1'b1;
`endif

  // Next-state and registered-output computation for the issue sequencer
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    is_clr_d    = is_clr_q;
    fpu_a_d     = fpu_a_q;
    fpu_b_d     = fpu_b_q;
    fpu_op_d    = fpu_op_q;
    we_d        = 1'b0;
    clr_d       = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          id_d = idx_s;
          if (adv_ptr_s) begin
            rr_ptr_d = ptr_next_s;
          end else begin
            rr_ptr_d = rr_ptr_q;
          end
          if (sel_fpu_s) begin
            // Strobes are registered here so they appear exactly in ISSUE
            fpu_a_d  = sel_a_s;
            fpu_b_d  = sel_b_s;
            fpu_op_d = sel_op_s;
            is_clr_d = sel_clr_s;
            we_d     = !sel_clr_s;
            clr_d    = sel_clr_s;
            state_d  = ISSUE;
          end else begin
            // Unimplemented op: answer immediately, FPU untouched
            rsp_id_d    = idx_s;
            rsp_data_d  = {DATA_WIDTH{1'b0}};
            rsp_flags_d = FLAGS_INVALID;
            state_d     = RESP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          rsp_id_d = id_q;
          if (is_clr_q) begin
            rsp_data_d  = {DATA_WIDTH{1'b0}};
            rsp_flags_d = 5'd0;
          end else begin
            rsp_data_d  = fpu_out_c;
            rsp_flags_d = fpu_exc_flags;
          end
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rsp_valid_d = (state_d == RESP);
  end

  // Sequencer state and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= {IDW{1'b0}};
      cnt_q       <= 4'd0;
      id_q        <= {IDW{1'b0}};
      is_clr_q    <= 1'b0;
      fpu_a_q     <= {DATA_WIDTH{1'b0}};
      fpu_b_q     <= {DATA_WIDTH{1'b0}};
      fpu_op_q    <= {CTRL_WIDTH{1'b0}};
      we_q        <= 1'b0;
      clr_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= {IDW{1'b0}};
      rsp_data_q  <= {DATA_WIDTH{1'b0}};
      rsp_flags_q <= 5'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      is_clr_q    <= is_clr_d;
      fpu_a_q     <= fpu_a_d;
      fpu_b_q     <= fpu_b_d;
      fpu_op_q    <= fpu_op_d;
      we_q        <= we_d;
      clr_q       <= clr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_flags     = rsp_flags_q;
  assign fpu_in_a      = fpu_a_q;
  assign fpu_in_b      = fpu_b_q;
  assign fpu_op_select = fpu_op_q;
  assign fpu_write_en  = we_q;
  assign fpu_clr_acc   = clr_q;

endmodule

// File: tb/tb_bf16_fpu_arbiter.sv
// Self-checking bench for bf16_fpu_arbiter: a fixed-latency FPU model,
// a response scoreboard and cycle-accurate strobe/response timing checks.
module tb_bf16_fpu_arbiter;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int CW  = 4;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N*CW-1:0] req_op;
`ifdef BF16_FPU_ARB_LOCK_EN
  logic [N-1:0]    req_lock;
`endif
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_data;
  logic [4:0]      rsp_flags;
  logic [DW-1:0]   fpu_in_a, fpu_in_b;
  logic [CW-1:0]   fpu_op_select;
  logic            fpu_write_en, fpu_clr_acc;
  logic [DW-1:0]   fpu_out_c;
  logic [4:0]      fpu_exc_flags;

  bf16_fpu_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .FPU_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
`ifdef BF16_FPU_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .fpu_in_a(fpu_in_a), .fpu_in_b(fpu_in_b), .fpu_op_select(fpu_op_select),
    .fpu_write_en(fpu_write_en), .fpu_clr_acc(fpu_clr_acc),
    .fpu_out_c(fpu_out_c), .fpu_exc_flags(fpu_exc_flags)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] d;
    logic [4:0]  f;
  } exp_t;
  exp_t sb[$];

  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference FPU behaviour for the operand pairs used here
  function automatic logic [20:0] fpu_model(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic acc_clr);
    logic [15:0] r;
    logic [4:0]  f;
    r = 16'h0BAD;
    f = 5'b11111;
    case (op)
      4'd0: begin
        if (a == 16'h4060 && b == 16'h3FC0) begin r = 16'h40A0; f = 5'd0; end
        else if (a == 16'h7F80 && b == 16'h3F80) begin r = 16'h7F80; f = 5'd0; end
        else if (a == 16'h7F7F && b == 16'h7F7F) begin r = 16'h7F80; f = 5'b00101; end
      end
      4'd1: if (a == 16'h3F80 && b == 16'h4000) begin r = acc_clr ? 16'h4000 : 16'h4200; f = 5'd0; end
      4'd2: if (a == 16'h3F80 && b == 16'h4000) begin r = 16'h4000; f = 5'd0; end
      4'd3: if (a == b) begin r = 16'h3F80; f = 5'd0; end
      default: r = 16'h0BAD;
    endcase
    return {f, r};
  endfunction

  // FPU model: result valid exactly LAT cycles after the write_en cycle
  logic [20:0] pipe [LAT];
  logic        acc_clr;
  always @(negedge clk) begin
    {fpu_exc_flags, fpu_out_c} <= pipe[LAT-1];
    for (int s = LAT - 1; s > 0; s--) pipe[s] <= pipe[s-1];
    pipe[0] <= fpu_write_en ? fpu_model(fpu_op_select, fpu_in_a, fpu_in_b, acc_clr)
                            : {5'b01010, 16'hDEAD};
    if (fpu_clr_acc) acc_clr <= 1'b1;
    else if (fpu_write_en && fpu_op_select == 4'd1) acc_clr <= 1'b0;
  end

  // Monitor: strobe bookkeeping and scoreboard pop on response handshake
  int          n_wr, n_clr, wr_cyc, rsp_start;
  logic [15:0] wr_a;
  logic        prev_rv;
  always @(negedge clk) begin
    prev_rv <= rsp_valid;
    if (fpu_write_en) begin
      n_wr   <= n_wr + 1;
      wr_cyc <= cyc;
      wr_a   <= fpu_in_a;
    end
    if (fpu_clr_acc) n_clr <= n_clr + 1;
    if (rsp_valid && !prev_rv) rsp_start <= cyc;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_data), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_data", 32'(rsp_data), 32'(e.d));
        check("rsp_flags", 32'(rsp_flags), 32'(e.f));
      end
    end
  end

  int last_acc;

  task automatic push_exp(input logic [1:0] id, input logic [15:0] d, input logic [4:0] f);
    sb.push_back({id, d, f});
  endtask

  // Raise a request and hold it until accepted (bounded)
  task automatic do_req(input int i, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    bit got;
    got = 1'b0;
    @(negedge clk);
    req_a[i*DW +: DW]  = a;
    req_b[i*DW +: DW]  = b;
    req_op[i*CW +: CW] = op;
    req_valid[i]       = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      #1;
      if (req_ready[i]) got = 1'b1;
      else @(negedge clk);
    end
    if (got) begin
      @(posedge clk);
      #1;
      last_acc = cyc;
    end
    req_valid[i] = 1'b0;
    check("accept_seen", 32'(got), 32'd1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  int a0, w0, c0, hs;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
`ifdef BF16_FPU_ARB_LOCK_EN
    req_lock = '0;
`endif
    repeat (3) @(negedge clk);
    #1;
    check("rst_rsp", 32'({rsp_valid, rsp_id, rsp_data, rsp_flags}), 32'd0);
    check("rst_fpu", 32'({fpu_write_en, fpu_clr_acc, fpu_op_select, fpu_in_a}), 32'd0);
    check("rst_fpu_b", 32'(fpu_in_b), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic ADD with latency checks
    w0 = n_wr;
    push_exp(2'd0, 16'h40A0, 5'd0);
    do_req(0, 4'd0, 16'h4060, 16'h3FC0);
    a0 = last_acc;
    wait_drain();
    check("t1_wr_cycle", 32'(wr_cyc), 32'(a0));
    check("t1_wr_a", 32'(wr_a), 32'h4060);
    check("t1_wr_count", 32'(n_wr - w0), 32'd1);
    check("t1_rsp_cycle", 32'(rsp_start), 32'(a0 + LAT + 1));

    // Two simultaneous MUL requests: id1 then id2
    push_exp(2'd1, 16'h4000, 5'd0);
    push_exp(2'd2, 16'h4000, 5'd0);
    fork
      do_req(1, 4'd2, 16'h3F80, 16'h4000);
      do_req(2, 4'd2, 16'h3F80, 16'h4000);
    join
    wait_drain();

    // CLR_ACC then MAC
    w0 = n_wr; c0 = n_clr;
    push_exp(2'd3, 16'h0000, 5'd0);
    do_req(3, 4'hF, 16'h1234, 16'h5678);
    wait_drain();
    check("t3_clr_pulses", 32'(n_clr - c0), 32'd1);
    check("t3_clr_no_wr", 32'(n_wr - w0), 32'd0);
    push_exp(2'd3, 16'h4000, 5'd0);
    do_req(3, 4'd1, 16'h3F80, 16'h4000);
    wait_drain();
    check("t3_mac_wr", 32'(n_wr - w0), 32'd1);

    // Unimplemented op: immediate NV response, FPU untouched
    w0 = n_wr; c0 = n_clr;
    push_exp(2'd0, 16'h0000, 5'b10000);
    do_req(0, 4'd10, 16'h1111, 16'h2222);
    a0 = last_acc;
    wait_drain();
    check("t4_rsp_cycle", 32'(rsp_start), 32'(a0));
    check("t4_no_strobe", 32'((n_wr - w0) + (n_clr - c0)), 32'd0);

    // Response backpressure with a competing request pending
    rsp_ready = 1'b0;
    push_exp(2'd1, 16'h3F80, 5'd0);
    do_req(1, 4'd3, 16'h3F80, 16'h3F80);
    for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
    check("t5_rsp_seen", 32'(rsp_valid), 32'd1);
    req_a[2*DW +: DW] = 16'h4060; req_b[2*DW +: DW] = 16'h3FC0; req_op[2*CW +: CW] = 4'd0;
    req_valid[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check("t5_hold_valid", 32'(rsp_valid), 32'd1);
      check("t5_hold_data", 32'(rsp_data), 32'h3F80);
      check("t5_hold_id", 32'(rsp_id), 32'd1);
      check("t5_hold_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    hs = cyc + 1;
    push_exp(2'd2, 16'h40A0, 5'd0);
    do_req(2, 4'd0, 16'h4060, 16'h3FC0);
    check("t5_accept_after_hs", 32'(last_acc), 32'(hs + 1));
    wait_drain();

    // Reset in WAIT abandons the op; pointer restarts at 0
    do_req(1, 4'd0, 16'h4060, 16'h3FC0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_rsp", 32'({rsp_valid, rsp_id, rsp_data, rsp_flags}), 32'd0);
    check("t6_rst_fpu", 32'({fpu_write_en, fpu_clr_acc, fpu_op_select, fpu_in_a}), 32'd0);
    check("t6_rst_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_exp(2'd1, 16'h7F80, 5'b00101);
    push_exp(2'd3, 16'h7F80, 5'd0);
    fork
      do_req(3, 4'd0, 16'h7F80, 16'h3F80);
      do_req(1, 4'd0, 16'h7F7F, 16'h7F7F);
    join
    wait_drain();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
